booth_seq_mac: RTL
==================

# booth_seq_mac

Iterative signed multiply-accumulate sequencer built on radix-2 Booth recoding of a WIDTH-bit multiplier. Accepts one operand pair per start, walks the multiplier's Booth codes one per cycle, and adds, subtracts or skips the shifted multiplicand into a 2*WIDTH-bit accumulator. Sits between the DMAC command logic and the register file as the multi-cycle MAC engine.

## Interface
- WIDTH, 64, operand width; result is 2*WIDTH bits
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- acc  in  1  sampled with start; 1 = accumulate onto current result, 0 = start from zero
- mcand  in  WIDTH  signed multiplicand (two's complement)
- mplier  in  WIDTH  signed multiplier (two's complement)
- busy  out  1  high in BUSY and DONE
- done  out  1  one-cycle pulse; result valid
- result  out  2*WIDTH  signed product/accumulation; held until next accepted start completes

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: start=1 latches mcand (sign-extended to 2*WIDTH), mplier, acc; accumulator <= acc ? result : 0; count <= 0; go BUSY. start=0 stays IDLE.
- BUSY: code i=count from pair {mplier[i], mplier[i-1]}, mplier[-1]=0.
  - 00 or 11: no change; 01: acc += mcand<<i; 10: acc -= mcand<<i.
  - All arithmetic modulo 2^(2*WIDTH); no overflow flag.
  - count==WIDTH-1 after processing: result <= accumulator, go DONE; else count+1.
- DONE: done=1 for one cycle; go IDLE.
- start in BUSY/DONE is ignored, not queued.
- result changes only on the BUSY->DONE edge (and reset).
- Reset (any state, any cycle): state IDLE, count 0, accumulator 0, result 0, busy 0, done 0; in-flight operation discarded.

## Timing
- Edge 0 samples start. BUSY occupies cycles 1..WIDTH. done=1 and result valid in cycle WIDTH+1 (65 at default). busy high cycles 1..WIDTH+1.
- Next start accepted earliest in cycle WIDTH+2.
- Throughput: one operation per WIDTH+2 cycles without early exit.
- No combinational path from inputs to outputs.

## Configuration
- BOOTH_SKIP_EN defined: in BUSY, after processing code i, if mplier[WIDTH-1:i] are all equal (all remaining codes zero), finish immediately: result <= accumulator, go DONE. Latency becomes (index of last nonzero code, or 0)+2 cycles to done.
- BOOTH_SKIP_EN undefined: fixed WIDTH+1 cycle latency; no early-exit logic.
- Result values identical in both builds.

## Structure
- Package booth_pkg: state enum (IDLE, BUSY, DONE), Booth code constants (ZERO=2'b00, SUB=2'b10, ADD=2'b01, ZERO_ALT=2'b11), default WIDTH.
- Sub-module booth_pair_decode: takes {mplier[i], mplier[i-1]}, outputs add/sub enables; combinational, instanced once with a muxed bit pair.
- Top holds FSM, counter, accumulator, shifter and adder/subtractor.

## Test plan
- Reset: assert reset mid-BUSY at cycle 30 -> busy=0, done=0, result=0 same cycle; next start behaves normally.
- mcand=3, mplier=5, acc=0 -> done in cycle 65, result=15; busy high cycles 1..65.
- mcand=-7, mplier=6 -> result=0xFFFF...FFD6 (-42); mcand=mplier=0x8000_0000_0000_0000 -> result=0x4000...0 (2^126).
- Accumulate: after result=15, start mcand=2, mplier=-3, acc=1 -> result=9.
- start pulsed in cycles 10 and 65 of an operation -> ignored; result and latency unchanged.
- BOOTH_SKIP_EN: mplier=0 -> done in cycle 2, result=0 (or prior value with acc=1); mplier=1, mcand=9 -> done in cycle 3, result=9; mplier=-1 -> done in cycle 2, result=-mcand.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and constants for the booth_seq_mac radix-2 Booth MAC engine.
package booth_pkg;

  localparam int unsigned DEF_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Booth codes formed as {mplier[i], mplier[i-1]}
  localparam logic [1:0] ZERO     = 2'b00;
  localparam logic [1:0] ADD      = 2'b01;
  localparam logic [1:0] SUB      = 2'b10;
  localparam logic [1:0] ZERO_ALT = 2'b11;

endpackage

// File: rtl/booth_pair_decode.sv
// Radix-2 Booth pair decoder: turns one multiplier bit pair into add/sub enables.
module booth_pair_decode
  import booth_pkg::*;
(
  input  logic [1:0] i_pair,
  output logic       o_add_c,
  output logic       o_sub_c
);

  // Decode the bit pair; both zero codes leave the accumulator untouched
  always_comb begin
    o_add_c = 1'b0;
    o_sub_c = 1'b0;
    case (i_pair)
      ADD:           o_add_c = 1'b1;
      SUB:           o_sub_c = 1'b1;
      ZERO, ZERO_ALT: ;
      default:       ;
    endcase
  end

endmodule

// File: rtl/booth_seq_mac.sv
// Iterative signed multiply-accumulate engine, one radix-2 Booth code per cycle.
// Optional build macro: BOOTH_SKIP_EN enables early exit once all remaining
// Booth codes are zero; results are identical with or without it.
module booth_seq_mac
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 acc,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned RES_W = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned IDX_W = $clog2(WIDTH + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_busy;
  logic               r_done;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_load;
  logic               w_step;
  logic               w_last;

  logic [RES_W-1:0]   r_mcand;
  logic [WIDTH:0]     r_mpx;      // multiplier with implicit mplier[-1]=0 at bit 0
  logic [RES_W-1:0]   r_acc;
  logic [RES_W-1:0]   r_result;
  logic [CNT_W-1:0]   r_count;

  logic [IDX_W-1:0]   w_idx;
  logic [1:0]         w_pair;
  logic               w_add;
  logic               w_sub;
  logic [RES_W-1:0]   w_shifted;
  logic [RES_W-1:0]   w_acc_step;

  assign w_idx     = IDX_W'(r_count);
  assign w_pair    = r_mpx[w_idx +: 2];
  assign w_shifted = r_mcand << r_count;

  booth_pair_decode u_decode (
    .i_pair  (w_pair),
    .o_add_c (w_add),
    .o_sub_c (w_sub)
  );

`ifdef BOOTH_SKIP_EN
  logic [WIDTH-1:0] w_mplier;
  logic [WIDTH-1:0] w_rest;

  // Remaining codes are all zero once mplier[WIDTH-1:count] is a run of equal bits;
  // at count==WIDTH-1 this is trivially true, so it also covers the final code.
  assign w_mplier = r_mpx[WIDTH:1];
  assign w_rest   = WIDTH'($signed(w_mplier) >>> r_count);
  assign w_last   = (w_rest == {WIDTH{w_mplier[WIDTH-1]}});
`else
  // Fixed-length walk over every Booth code
  assign w_last = (r_count == CNT_W'(WIDTH - 1));
`endif

  // Add, subtract or keep the shifted multiplicand for the current code
  always_comb begin
    w_acc_step = r_acc;
    if (w_add) begin
      w_acc_step = r_acc + w_shifted;
    end else if (w_sub) begin
      w_acc_step = r_acc - w_shifted;
    end
  end

  // Control state register with registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state, next-status and datapath enables
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = BUSY;
          w_busy_nxt  = 1'b1;
          w_load      = 1'b1;
        end
      end
      BUSY: begin
        w_busy_nxt = 1'b1;
        w_step     = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, accumulation and result commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mpx    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_count  <= '0;
    end else if (w_load) begin
      r_mcand <= {{WIDTH{mcand[WIDTH-1]}}, mcand};
      r_mpx   <= {mplier, 1'b0};
      r_acc   <= acc ? r_result : '0;
      r_count <= '0;
    end else if (w_step) begin
      r_acc   <= w_acc_step;
      r_count <= r_count + CNT_W'(1);
      if (w_last) begin
        r_result <= w_acc_step;
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
